io_window_decoder: RTL and testbench



---
 rtl/io_window_decoder.sv | 131 +++++++++++++
 tb/tb_io_window_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_window_decoder.sv
// io_window_decoder: registered base/mask I/O window decoder with a lockable config block
// and a timed default responder for ports no window claims.
module io_window_decoder #(
  parameter int                    NUM_WIN   = 16,
  parameter logic [15:0]           CFG_BASE  = 16'hFFC0,
  parameter int                    TIMEOUT   = 8,
  parameter logic [NUM_WIN*16-1:0] INIT_BASE = '0,
  parameter logic [NUM_WIN*16-1:0] INIT_MASK = '0,
  parameter logic [NUM_WIN-1:0]    INIT_EN   = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               d_io,
  input  logic [19:1]        data_m_addr,
  input  logic               data_m_access,
  input  logic               data_m_wr_en,
  input  logic [1:0]         data_m_bytesel,
  input  logic [15:0]        data_m_data_in,
  output logic [15:0]        data_m_data_out,
  output logic               data_m_ack,
  output logic [NUM_WIN-1:0] win_select,
  output logic               default_io_access,
  output logic               cfg_locked
);
  localparam int IW = NUM_WIN > 1 ? $clog2(NUM_WIN) : 1;
  typedef enum logic [2:0] {IDLE, CFG, DEF, PERIPH, HOLD} state_t;
  state_t             r_state;
  logic [15:0]        r_base [NUM_WIN];
  logic [15:0]        r_mask [NUM_WIN];
  logic [NUM_WIN-1:0] r_en, r_sel;
  logic [IW-1:0]      r_idx;
  logic [1:0]         r_off, r_be;
  logic [15:0]        r_wdata, r_dout;
  logic [7:0]         r_cnt;
  logic               r_lock, r_ack, r_def, r_wr;
  logic [15:0]        w_port, w_rdata, w_wdat;
  logic [NUM_WIN-1:0] w_hit, w_pick;
  logic               w_live, w_cfg_hit, w_vld, w_miss, w_unused;

  assign w_port    = {data_m_addr[15:1], 1'b0};
  assign w_unused  = ^data_m_addr[19:16];
  assign w_live    = d_io && data_m_access;
  assign w_cfg_hit = w_port[15:3] == CFG_BASE[15:3];
  assign w_pick    = w_hit & (~w_hit + NUM_WIN'(1));
  assign w_miss    = !w_cfg_hit && w_hit == '0;
  assign w_vld     = int'(r_idx) < NUM_WIN;

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_hit
    assign w_hit[i] = r_en[i] && ((w_port ^ r_base[i]) & ~r_mask[i]) == 16'h0;
  end

  assign w_rdata = r_off == 2'd0 ? 16'(r_idx) :
                   !w_vld        ? 16'h0 :
                   r_off == 2'd1 ? r_base[r_idx] :
                   r_off == 2'd2 ? r_mask[r_idx] : {r_lock, 14'h0, r_en[r_idx]};
  // Byte-lane merge of the latched write data over the register's current value
  assign w_wdat = {r_be[1] ? r_wdata[15:8] : w_rdata[15:8], r_be[0] ? r_wdata[7:0] : w_rdata[7:0]};

  assign data_m_data_out   = r_dout;
  assign data_m_ack        = r_ack;
  assign win_select        = r_sel;
  assign default_io_access = r_def;
  assign cfg_locked        = r_lock;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_WIN; k++) begin
        r_base[k] <= INIT_BASE[16*k +: 16];
        r_mask[k] <= INIT_MASK[16*k +: 16];
      end
      r_en    <= INIT_EN;
      r_state <= IDLE;
      r_sel   <= '0;
      r_idx   <= '0;
      r_off   <= 2'd0;
      r_be    <= 2'd0;
      r_wdata <= 16'h0;
      r_dout  <= 16'h0;
      r_cnt   <= 8'h0;
      r_lock  <= 1'b0;
      r_ack   <= 1'b0;
      r_def   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_dout <= 16'h0;
      r_wr   <= 1'b0;
      if (r_wr) begin
        if (r_off == 2'd0) r_idx <= w_wdat[IW-1:0];
        if (w_vld && !r_lock && r_off == 2'd1) r_base[r_idx] <= w_wdat;
        if (w_vld && !r_lock && r_off == 2'd2) r_mask[r_idx] <= w_wdat;
        if (w_vld && !r_lock && r_off == 2'd3 && r_be[0]) r_en[r_idx] <= r_wdata[0];
        if (r_off == 2'd3 && r_be[1] && r_wdata[15]) r_lock <= 1'b1;
      end
      if (r_state != IDLE && !w_live) begin
        r_state <= IDLE;
        r_sel   <= '0;
        r_def   <= 1'b0;
        r_cnt   <= 8'h0;
      end else begin
        case (r_state)
          IDLE: if (w_live) begin
            r_sel   <= w_cfg_hit ? '0 : w_pick;
            r_def   <= w_miss;
            r_off   <= w_port[2:1];
            r_cnt   <= w_miss ? 8'd1 : 8'd0;
            r_state <= w_cfg_hit ? CFG : w_miss ? DEF : PERIPH;
          end
          CFG: begin
            r_ack   <= 1'b1;
            r_dout  <= w_rdata;
            r_wr    <= data_m_wr_en;
            r_wdata <= data_m_data_in;
            r_be    <= data_m_bytesel;
            r_state <= HOLD;
          end
          DEF: if (r_cnt == 8'(TIMEOUT)) begin
            r_ack   <= 1'b1;
            r_dout  <= 16'hFFFF;
            r_def   <= 1'b0;
            r_cnt   <= 8'h0;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_io_window_decoder.sv
// tb_io_window_decoder: scoreboard bench; expected per-access results are queued by the
// driver and compared by a monitor once the access has ended and its selects should be clear.
module tb_io_window_decoder;
  localparam logic [255:0] IB = (256'h0040 << 80) | (256'h0040 << 32) | 256'h0020;
  localparam logic [255:0] IM = (256'h0003 << 80) | (256'h001F << 32) | 256'h0002;
  localparam logic [15:0]  IE = 16'b0000_0000_0010_0101;

  logic        clk = 1'b0, reset_n = 1'b0, d_io = 1'b0;
  logic [19:1] data_m_addr = '0;
  logic        data_m_access = 1'b0, data_m_wr_en = 1'b0;
  logic [1:0]  data_m_bytesel = 2'b00;
  logic [15:0] data_m_data_in = 16'h0, data_m_data_out;
  logic        data_m_ack, default_io_access, cfg_locked;
  logic [15:0] win_select;

  int n_chk = 0, n_err = 0;

  typedef struct {
    string       tag;
    logic [15:0] sel;
    logic        def;
    int          ack_cyc;
    logic        chk;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  io_window_decoder #(.NUM_WIN(16), .CFG_BASE(16'hFFC0), .TIMEOUT(8),
                      .INIT_BASE(IB), .INIT_MASK(IM), .INIT_EN(IE)) dut (
    .clk(clk), .reset_n(reset_n), .d_io(d_io), .data_m_addr(data_m_addr),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_data_in(data_m_data_in),
    .data_m_data_out(data_m_data_out), .data_m_ack(data_m_ack),
    .win_select(win_select), .default_io_access(default_io_access),
    .cfg_locked(cfg_locked)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic [15:0] esel, input logic edef,
                          input int eack, input logic echk, input logic [15:0] edata);
    exp_t e;
    e.tag = tag; e.sel = esel; e.def = edef; e.ack_cyc = eack; e.chk = echk; e.data = edata;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] port, input logic wr, input logic [15:0] wd,
                       input logic [1:0] be);
    @(posedge clk); #1;
    d_io = 1'b1; data_m_addr = {4'b0, port[15:1]}; data_m_wr_en = wr;
    data_m_data_in = wd; data_m_bytesel = be; data_m_access = 1'b1;
  endtask

  task automatic release_bus();
    #1;
    data_m_access = 1'b0; d_io = 1'b0; data_m_wr_en = 1'b0; data_m_data_in = 16'h0;
    repeat (3) @(posedge clk);
  endtask

  // hold > 0: drop the access after that many cycles; hold == 0: hold until ack (bounded)
  task automatic access(input string tag, input logic [15:0] port, input logic wr,
                        input logic [15:0] wd, input logic [1:0] be, input int hold,
                        input logic [15:0] esel, input logic edef, input int eack,
                        input logic echk, input logic [15:0] edata);
    push_exp(tag, esel, edef, eack, echk, edata);
    drive(port, wr, wd, be);
    if (hold > 0) repeat (hold) @(posedge clk);
    else begin
      int n = 0;
      while (!data_m_ack && n < 300) begin @(negedge clk); n++; end
      @(posedge clk);
    end
    release_bus();
  endtask

  task automatic cfg_wr(input string tag, input logic [15:0] port, input logic [15:0] wd,
                        input logic [1:0] be);
    access(tag, port, 1'b1, wd, be, 0, 16'h0, 1'b0, 2, 1'b0, 16'h0);
  endtask

  task automatic cfg_rd(input string tag, input logic [15:0] port, input logic [15:0] ed);
    access(tag, port, 1'b0, 16'h0, 2'b11, 0, 16'h0, 1'b0, 2, 1'b1, ed);
  endtask

  task automatic io(input string tag, input logic [15:0] port, input int hold,
                    input logic [15:0] esel, input logic edef);
    access(tag, port, 1'b0, 16'h0, 2'b11, hold, esel, edef, -1, 1'b0, 16'h0);
  endtask

  initial begin
    int cyc = 0, acks = 0, ack_cyc = -1;
    logic [15:0] sel1 = '0, ack_data = '0;
    logic def1 = 1'b0, bad = 1'b0, active = 1'b0, low = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!active && data_m_access) begin
        active = 1'b1; low = 1'b0; cyc = 0; acks = 0; ack_cyc = -1;
        ack_data = '0; bad = 1'b0; sel1 = '0; def1 = 1'b0;
      end else if (active) cyc++;
      if (active) begin
        if (cyc == 1) begin sel1 = win_select; def1 = default_io_access; end
        if (data_m_ack) begin acks++; ack_cyc = cyc; ack_data = data_m_data_out; end
        else if (data_m_data_out != 16'h0) bad = 1'b1;
        if (!data_m_access && low) begin
          active = 1'b0;
          if (exp_q.size() == 0) check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check_val({e.tag, "_sel"}, 32'(sel1), 32'(e.sel));
            check_val({e.tag, "_def"}, 32'(def1), 32'(e.def));
            check_val({e.tag, "_nack"}, acks, e.ack_cyc >= 0 ? 1 : 0);
            if (e.ack_cyc >= 0) check_val({e.tag, "_ackcyc"}, ack_cyc, e.ack_cyc);
            if (e.chk) check_val({e.tag, "_data"}, 32'(ack_data), 32'(e.data));
            check_val({e.tag, "_idle_dout"}, 32'(bad), 32'd0);
            check_val({e.tag, "_clr"}, {15'h0, default_io_access, win_select}, 32'd0);
          end
        end else if (!data_m_access) low = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    check_val("rst_sel", 32'(win_select), 32'd0);
    check_val("rst_def", 32'(default_io_access), 32'd0);
    check_val("rst_ack", 32'(data_m_ack), 32'd0);
    check_val("rst_dout", 32'(data_m_data_out), 32'd0);
    check_val("rst_lock", 32'(cfg_locked), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    io("win0", 16'h0022, 4, 16'h0001, 1'b0);
    io("overlap", 16'h0042, 4, 16'h0004, 1'b0);

    cfg_wr("wr_idx", 16'hFFC0, 16'h0003, 2'b11);
    cfg_wr("wr_base", 16'hFFC2, 16'h03F8, 2'b11);
    cfg_wr("wr_mask", 16'hFFC4, 16'hAB07, 2'b01);
    cfg_wr("wr_ctrl", 16'hFFC6, 16'h0001, 2'b11);
    io("win3", 16'h03FC, 4, 16'h0008, 1'b0);
    cfg_rd("rd_base", 16'hFFC2, 16'h03F8);
    cfg_rd("rd_mask_lane", 16'hFFC4, 16'h0007);
    cfg_rd("rd_idx", 16'hFFC0, 16'h0003);
    cfg_rd("rd_ctrl", 16'hFFC6, 16'h0001);

    access("default", 16'h0300, 1'b0, 16'h0, 2'b11, 0, 16'h0, 1'b1, 9, 1'b1, 16'hFFFF);

    cfg_wr("wr_lock", 16'hFFC6, 16'h8001, 2'b11);
    check_val("locked", 32'(cfg_locked), 32'd1);
    cfg_wr("wr_base_locked", 16'hFFC2, 16'h1234, 2'b11);
    cfg_rd("rd_base_locked", 16'hFFC2, 16'h03F8);
    cfg_rd("rd_ctrl_locked", 16'hFFC6, 16'h8001);
    cfg_wr("wr_idx_locked", 16'hFFC0, 16'h0005, 2'b11);
    cfg_rd("rd_base5", 16'hFFC2, 16'h0040);

    io("abort", 16'h0300, 4, 16'h0, 1'b1);
    io("after_abort", 16'h0022, 3, 16'h0001, 1'b0);

    push_exp("rst_mid", 16'h0, 1'b1, -1, 1'b0, 16'h0);
    drive(16'h0300, 1'b0, 16'h0, 2'b11);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b0; #1;
    check_val("mid_sel", 32'(win_select), 32'd0);
    check_val("mid_def", 32'(default_io_access), 32'd0);
    check_val("mid_ack", 32'(data_m_ack), 32'd0);
    check_val("mid_dout", 32'(data_m_data_out), 32'd0);
    check_val("mid_lock", 32'(cfg_locked), 32'd0);
    @(posedge clk);
    release_bus();
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    cfg_rd("post_ctrl0", 16'hFFC6, 16'h0001);
    cfg_rd("post_idx", 16'hFFC0, 16'h0000);
    cfg_wr("post_wr_idx", 16'hFFC0, 16'h0003, 2'b11);
    cfg_rd("post_base3", 16'hFFC2, 16'h0000);
    io("post_win3_off", 16'h03FC, 3, 16'h0, 1'b1);

    repeat (3) @(posedge clk);
    check_val("q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
